parking_exit_controller: RTL and testbench



---
 rtl/parking_pkg.sv | 15 +
 rtl/gate_pulse_timer.sv | 36 +++
 rtl/parking_exit_controller.sv | 188 ++++++++++++++++++
 tb/tb_parking_exit_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking exit path.
package parking_pkg;

    localparam int DEF_TIME_W = 32;
    localparam int DEF_ID_W   = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CALC,
        S_AWAIT_PAY,
        S_OPEN
    } exit_state_e;

endpackage

// File: rtl/gate_pulse_timer.sv
// Loadable down-counter: holds the barrier open for CYCLES cycles.
// It also flags the first and last open cycles.
module gate_pulse_timer #(
    parameter int CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_gate_open,
    output logic o_first,
    output logic o_last
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_first <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= CW'(CYCLES);
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_gate_open = (r_cnt != '0);
    assign o_first     = r_first;
    assign o_last      = (r_cnt == CW'(1));

endmodule

// File: rtl/parking_exit_controller.sv
// Exit controller: looks up the entry time, charges the fee, collects payment and opens the gate.
// Define PARKING_EXIT_PAY_TIMEOUT_EN to abandon stalled payments and issue a refund.
module parking_exit_controller
    import parking_pkg::*;
#(
    parameter int TIME_W           = DEF_TIME_W,
    parameter int ID_W             = DEF_ID_W,
    parameter int RATE             = 1,
    parameter int MIN_FEE          = 1,
    parameter int GATE_OPEN_CYCLES = 8
`ifdef PARKING_EXIT_PAY_TIMEOUT_EN
    , parameter int PAY_TIMEOUT    = 1000
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   exit_req,
    input  logic [ID_W-1:0]        exit_id,
    output logic                   exit_ready,
    input  logic [(2**ID_W)-1:0]   slot_valid,
    input  logic [TIME_W-1:0]      current_time,
    output logic                   rd_en,
    output logic [ID_W-1:0]        rd_id,
    input  logic [TIME_W-1:0]      rd_data,
    output logic [TIME_W-1:0]      fee,
    output logic                   fee_valid,
    input  logic                   pay_valid,
    input  logic [TIME_W-1:0]      pay_amount,
    output logic                   pay_ready,
    output logic [TIME_W-1:0]      change,
    output logic                   gate_open,
    output logic                   car_exit_pulse,
    output logic                   slot_release,
    output logic [ID_W-1:0]        release_id,
    output logic                   err_pulse
`ifdef PARKING_EXIT_PAY_TIMEOUT_EN
    , output logic                 refund_valid
    , output logic [TIME_W-1:0]    refund_amount
`endif
);

    localparam logic [TIME_W-1:0] SAT_MAX = '1;

    exit_state_e r_state, w_next;

    logic [ID_W-1:0]     r_id;
    logic                r_calc_ph;
    logic [TIME_W-1:0]   r_entry, r_now, r_fee, r_paid, r_change;
    logic                r_err;

    logic                w_accept, w_slot_ok, w_beat, w_paid_done, w_load;
    logic [TIME_W:0]     w_paid_sum;
    logic [TIME_W-1:0]   w_paid_upd, w_dur, w_prod_sat, w_fee_calc;
    logic [2*TIME_W-1:0] w_prod;
    logic                w_gate_open, w_first, w_gate_last;

    assign w_accept  = exit_req && (r_state == S_IDLE);
    assign w_slot_ok = slot_valid[exit_id];
    assign w_beat    = pay_valid && (r_state == S_AWAIT_PAY);

    assign w_paid_sum  = {1'b0, r_paid} + {1'b0, pay_amount};
    assign w_paid_upd  = !w_beat ? r_paid : (w_paid_sum[TIME_W] ? SAT_MAX : w_paid_sum[TIME_W-1:0]);
    assign w_paid_done = (w_paid_upd >= r_fee);
    assign w_load      = w_beat && w_paid_done;

    // Unsigned subtraction wraps naturally across a timer rollover.
    assign w_dur      = r_now - r_entry;
    assign w_prod     = (2*TIME_W)'(w_dur) * (2*TIME_W)'(RATE);
    assign w_prod_sat = (|w_prod[2*TIME_W-1:TIME_W]) ? SAT_MAX : w_prod[TIME_W-1:0];
    assign w_fee_calc = (w_prod_sat < TIME_W'(MIN_FEE)) ? TIME_W'(MIN_FEE) : w_prod_sat;

`ifdef PARKING_EXIT_PAY_TIMEOUT_EN
    logic [31:0]       r_to_cnt;
    logic              r_refund_valid;
    logic [TIME_W-1:0] r_refund_amt;
    logic              w_timeout;

    assign w_timeout = (r_state == S_AWAIT_PAY) && !w_beat && ((r_to_cnt + 32'd1) == 32'(PAY_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt       <= '0;
            r_refund_valid <= 1'b0;
            r_refund_amt   <= '0;
        end else begin
            r_refund_valid <= w_timeout;
            if (w_timeout) r_refund_amt <= r_paid;
            if (r_state != S_AWAIT_PAY || w_beat || w_timeout) r_to_cnt <= '0;
            else                                               r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    assign refund_valid  = r_refund_valid;
    assign refund_amount = r_refund_amt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_accept && w_slot_ok) w_next = S_LOOKUP;
            S_LOOKUP:    w_next = S_CALC;
            S_CALC:      if (r_calc_ph) w_next = S_AWAIT_PAY;
            S_AWAIT_PAY: begin
                if (w_load) w_next = S_OPEN;
`ifdef PARKING_EXIT_PAY_TIMEOUT_EN
                else if (w_timeout) w_next = S_IDLE;
`endif
            end
            S_OPEN:      if (w_gate_last) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        exit_ready = 1'b0;
        rd_en      = 1'b0;
        fee_valid  = 1'b0;
        pay_ready  = 1'b0;
        case (r_state)
            S_IDLE:      exit_ready = 1'b1;
            S_LOOKUP:    rd_en      = 1'b1;
            S_AWAIT_PAY: begin
                fee_valid = 1'b1;
                pay_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // CALC takes two cycles: capture operands, then register the fee.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id      <= '0;
            r_calc_ph <= 1'b0;
            r_entry   <= '0;
            r_now     <= '0;
            r_fee     <= '0;
            r_paid    <= '0;
            r_change  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err     <= w_accept && !w_slot_ok;
            r_calc_ph <= (r_state == S_CALC) && !r_calc_ph;
            if (w_accept) r_id <= exit_id;
            if (w_accept && w_slot_ok) begin
                r_fee    <= '0;
                r_change <= '0;
            end
            if (r_state == S_CALC && !r_calc_ph) begin
                r_entry <= rd_data;
                r_now   <= current_time;
            end
            if (r_state == S_CALC && r_calc_ph) r_fee <= w_fee_calc;
            if (r_state == S_AWAIT_PAY) r_paid <= w_paid_upd;
            if (w_load) r_change <= w_paid_upd - r_fee;
            if (r_state == S_OPEN && w_gate_last) r_paid <= '0;
`ifdef PARKING_EXIT_PAY_TIMEOUT_EN
            if (w_timeout) r_paid <= '0;
`endif
        end
    end

    gate_pulse_timer #(
        .CYCLES (GATE_OPEN_CYCLES)
    ) u_gate (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .o_gate_open (w_gate_open),
        .o_first     (w_first),
        .o_last      (w_gate_last)
    );

    assign rd_id          = r_id;
    assign fee            = r_fee;
    assign change         = r_change;
    assign gate_open      = w_gate_open;
    assign car_exit_pulse = w_first;
    assign slot_release   = w_first;
    assign release_id     = r_id;
    assign err_pulse      = r_err;

endmodule

// File: tb/tb_parking_exit_controller.sv
// Directed scoreboard bench for parking_exit_controller (RATE=2, 8-cycle gate).
module tb_parking_exit_controller;

    localparam int TW  = 32;
    localparam int IW  = 2;
    localparam int NS  = 4;
    localparam int GOC = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          exit_req = 1'b0;
    logic [IW-1:0] exit_id = '0;
    logic          exit_ready;
    logic [NS-1:0] slot_valid = '0;
    logic [TW-1:0] current_time = '0;
    logic          rd_en;
    logic [IW-1:0] rd_id;
    logic [TW-1:0] rd_data = '0;
    logic [TW-1:0] fee;
    logic          fee_valid;
    logic          pay_valid = 1'b0;
    logic [TW-1:0] pay_amount = '0;
    logic          pay_ready;
    logic [TW-1:0] change;
    logic          gate_open, car_exit_pulse, slot_release, err_pulse;
    logic [IW-1:0] release_id;
`ifdef PARKING_EXIT_PAY_TIMEOUT_EN
    logic          refund_valid;
    logic [TW-1:0] refund_amount;
`endif

    parking_exit_controller #(
        .TIME_W(TW), .ID_W(IW), .RATE(2), .MIN_FEE(1), .GATE_OPEN_CYCLES(GOC)
`ifdef PARKING_EXIT_PAY_TIMEOUT_EN
        , .PAY_TIMEOUT(20)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .exit_req(exit_req), .exit_id(exit_id),
        .exit_ready(exit_ready), .slot_valid(slot_valid), .current_time(current_time),
        .rd_en(rd_en), .rd_id(rd_id), .rd_data(rd_data), .fee(fee), .fee_valid(fee_valid),
        .pay_valid(pay_valid), .pay_amount(pay_amount), .pay_ready(pay_ready),
        .change(change), .gate_open(gate_open), .car_exit_pulse(car_exit_pulse),
        .slot_release(slot_release), .release_id(release_id), .err_pulse(err_pulse)
`ifdef PARKING_EXIT_PAY_TIMEOUT_EN
        , .refund_valid(refund_valid), .refund_amount(refund_amount)
`endif
    );

    always #5 clk = ~clk;

    // Entry-time storage model: one-cycle read latency.
    logic [TW-1:0] mem [NS];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_id];

    typedef struct packed { logic [IW-1:0] id; logic [TW-1:0] chg; } rel_t;
    logic [TW-1:0] q_fee[$];
    rel_t          q_rel[$];

    int checks = 0, errors = 0;
    int n_rd = 0, n_exit = 0, n_err = 0, gate_len = 0;
    logic fv_q = 1'b0, go_q = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            fv_q = 1'b0; go_q = 1'b0; gate_len = 0;
        end else begin
            if (rd_en) n_rd++;
            if (err_pulse) n_err++;
            if (fee_valid && !fv_q) begin
                chk("fee_expected", 64'(q_fee.size() != 0), 1);
                if (q_fee.size() != 0) chk("fee", fee, q_fee.pop_front());
            end
            if (car_exit_pulse) begin
                rel_t r;
                n_exit++;
                chk("slot_release_with_exit", slot_release, 1);
                chk("exit_expected", 64'(q_rel.size() != 0), 1);
                if (q_rel.size() != 0) begin
                    r = q_rel.pop_front();
                    chk("release_id", release_id, r.id);
                    chk("change", change, r.chg);
                end
            end else if (slot_release) chk("release_without_exit", slot_release, 0);
            if (gate_open) gate_len++;
            else if (go_q) begin
                chk("gate_len", gate_len, GOC);
                gate_len = 0;
            end
            fv_q = fee_valid;
            go_q = gate_open;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic req(input logic [IW-1:0] id);
        exit_req = 1'b1; exit_id = id;
        step();
        exit_req = 1'b0;
    endtask

    task automatic pay(input logic [TW-1:0] amt);
        pay_valid = 1'b1; pay_amount = amt;
        step();
        pay_valid = 1'b0;
    endtask

    task automatic wait_fee(output int n);
        n = 0;
        while (!fee_valid && n < 20) begin step(); n++; end
        chk("fee_valid_seen", fee_valid, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!exit_ready && n < 50) begin step(); n++; end
        chk("return_idle", exit_ready, 1);
        step(); step();
    endtask

    task automatic run_exit(input logic [IW-1:0] id, input int npay,
                            input logic [TW-1:0] a1, input logic [TW-1:0] a2);
        int n;
        req(id);
        wait_fee(n);
        pay(a1);
        if (npay > 1) pay(a2);
        wait_idle();
    endtask

    initial begin
        int n, e0, r0, x0;
        for (int i = 0; i < NS; i++) mem[i] = '0;

        // Reset state
        repeat (3) step();
        chk("reset_outs", {gate_open, fee_valid, rd_en, err_pulse, car_exit_pulse, slot_release,
                           pay_ready, rd_id, release_id, fee, change}, 0);
        rst_n = 1'b1;
        step();

        // Main flow: fee 100, pays 60+50, change 10; extra request while awaiting pay
        mem[1] = 100; slot_valid = 4'b1010; current_time = 150;
        q_fee.push_back(100); q_rel.push_back('{id: 2'd1, chg: 32'd10});
        r0 = n_rd;
        req(1);
        chk("lookup_rd", {rd_en, rd_id, exit_ready}, {1'b1, 2'd1, 1'b0});
        wait_fee(n);
        chk("fee_latency", n, 3);
        chk("rd_count", n_rd - r0, 1);
        chk("ready_in_await", exit_ready, 0);
        exit_req = 1'b1; exit_id = 3;
        step(); step();
        exit_req = 1'b0;
        chk("ignored_req", {fee_valid, pay_ready}, 2'b11);
        pay(60);
        chk("partial_pay_waits", {fee_valid, gate_open}, 2'b10);
        x0 = n_exit;
        pay(50);
        chk("gate_opened", gate_open, 1);
        wait_idle();
        chk("one_exit", n_exit - x0, 1);
        chk("rd_count_total", n_rd - r0, 1);

        // Unoccupied slot
        e0 = n_err; r0 = n_rd;
        req(2);
        chk("err_pulse_hi", {err_pulse, exit_ready}, 2'b11);
        step();
        chk("err_pulse_lo", err_pulse, 0);
        step();
        chk("err_count", n_err - e0, 1);
        chk("err_no_rd", n_rd - r0, 0);

        // Timer wrap: 0x10 - 0xFFFFFFF0 = 32 ticks -> 64
        mem[3] = 32'hFFFF_FFF0; current_time = 32'h0000_0010;
        q_fee.push_back(64); q_rel.push_back('{id: 2'd3, chg: 32'd6});
        run_exit(3, 1, 70, 0);

        // Zero duration -> minimum fee, exact payment
        mem[1] = 500; current_time = 500;
        q_fee.push_back(1); q_rel.push_back('{id: 2'd1, chg: 32'd0});
        run_exit(1, 1, 1, 0);

        // Product saturation and saturating payment accumulation
        mem[3] = 0; current_time = 32'h8000_0000;
        q_fee.push_back(32'hFFFF_FFFF); q_rel.push_back('{id: 2'd3, chg: 32'd0});
        run_exit(3, 2, 32'hF000_0000, 32'h2000_0000);

        // Reset while the gate is open
        mem[1] = 200; current_time = 210;
        q_fee.push_back(20); q_rel.push_back('{id: 2'd1, chg: 32'd5});
        req(1);
        wait_fee(n);
        pay(25);
        step(); step();
        chk("gate_before_reset", gate_open, 1);
        x0 = n_exit;
        rst_n = 1'b0;
        #1;
        chk("gate_async_close", gate_open, 0);
        step(); step();
        chk("reset_no_pulse", {car_exit_pulse, slot_release, fee, change}, 0);
        rst_n = 1'b1;
        step(); step();
        chk("reset_no_exit", n_exit - x0, 0);
        chk("ready_after_reset", exit_ready, 1);

`ifdef PARKING_EXIT_PAY_TIMEOUT_EN
        // Payment stalls: refund after 20 idle cycles, gate stays shut
        mem[3] = 0; current_time = 50;
        q_fee.push_back(100);
        x0 = n_exit;
        req(3);
        wait_fee(n);
        pay(30);
        n = 0;
        while (!refund_valid && n < 100) begin step(); n++; end
        chk("timeout_latency", n, 20);
        chk("refund", {refund_valid, refund_amount}, {1'b1, 32'd30});
        chk("timeout_idle", {exit_ready, gate_open}, 2'b10);
        step();
        chk("refund_pulse_lo", refund_valid, 0);
        chk("timeout_no_exit", n_exit - x0, 0);
`endif

        step();
        chk("fee_queue_drained", q_fee.size(), 0);
        chk("rel_queue_drained", q_rel.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
